// File: rtl/seven_segment_ctrl.sv
// Bus-mapped sequencer for the 32-bit hex display path.
// Holds the shown word, a freeze buffer and the upper/lower half select.
module seven_segment_ctrl #(
    parameter int unsigned DEFAULT_PERIOD = 50000000,
    parameter logic [31:0] RESET_DATA     = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic [31:0] o_data,
    output logic        o_mode
);

    localparam logic [31:0] PERIOD_RST =
        (DEFAULT_PERIOD == 0) ? 32'd1 : 32'(DEFAULT_PERIOD);

    typedef enum logic {
        MANUAL,
        ALTERNATE
    } state_e;

    state_e      state_q;
    logic [31:0] data_q, data_d;
    logic [31:0] pend_q, pend_d;
    logic        flag_q, flag_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q;
    logic        mode_q;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;

    logic wr, wr_data, wr_ctrl, wr_per;

    assign wr      = i_req & i_we;
    assign wr_data = wr & (i_addr == 2'd0);
    assign wr_ctrl = wr & (i_addr == 2'd1);
    assign wr_per  = wr & (i_addr == 2'd2);

    always_comb begin
        rd_mux = '0;
        unique case (i_addr)
            2'd0: rd_mux = data_q;
            2'd1: rd_mux = {29'd0, ctrl_q};
            2'd2: rd_mux = period_q;
            2'd3: rd_mux = {30'd0, flag_q, mode_q};
        endcase
    end

    always_comb begin
        data_d   = data_q;
        pend_d   = pend_q;
        flag_d   = flag_q;
        ctrl_d   = ctrl_q;
        period_d = period_q;
        ack_d    = i_req;
        rdata_d  = (i_req && !i_we) ? rd_mux : '0;
        if (wr_data) begin
            if (ctrl_q[2]) begin
                pend_d = i_wdata;
                flag_d = 1'b1;
            end else begin
                data_d = i_wdata;
            end
        end
        if (wr_ctrl) begin
            ctrl_d = i_wdata[2:0];
            // Dropping FREEZE publishes the buffered word immediately
            if (ctrl_q[2] && !i_wdata[2] && flag_q) begin
                data_d = pend_q;
                flag_d = 1'b0;
            end
        end
        if (wr_per) begin
            period_d = (i_wdata == '0) ? 32'd1 : i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q   <= RESET_DATA;
            pend_q   <= '0;
            flag_q   <= 1'b0;
            ctrl_q   <= '0;
            period_q <= PERIOD_RST;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            data_q   <= data_d;
            pend_q   <= pend_d;
            flag_q   <= flag_d;
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= MANUAL;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                MANUAL: begin
                    cnt_q <= '0;
                    if (wr_ctrl && i_wdata[0]) begin
                        state_q <= ALTERNATE;
                    end else if (wr_ctrl) begin
                        mode_q <= i_wdata[1];
                    end else begin
                        mode_q <= ctrl_q[1];
                    end
                end
                ALTERNATE: begin
                    if (wr_ctrl && !i_wdata[0]) begin
                        state_q <= MANUAL;
                        mode_q  <= i_wdata[1];
                        cnt_q   <= '0;
                    end else if (wr_per) begin
                        // New period restarts the dwell; no toggle now
                        cnt_q <= '0;
                    end else if (cnt_q == period_q - 32'd1) begin
                        mode_q <= ~mode_q;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
            endcase
        end
    end

    assign o_ack   = ack_q;
    assign o_rdata = rdata_q;
    assign o_data  = data_q;
    assign o_mode  = mode_q;

endmodule

// File: tb/tb_seven_segment_ctrl.sv
// Random bus traffic against a timeline model of seven_segment_ctrl.
// Alternate-mode half select is derived from elapsed cycles since anchor.
module tb_seven_segment_ctrl;

    localparam int unsigned DEF_P = 50000000;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack, mode;
    logic [31:0] rdata, data;

    int n_chk  = 0;
    int n_pass = 0;

    seven_segment_ctrl #(
        .DEFAULT_PERIOD(DEF_P),
        .RESET_DATA    (32'h00000000)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_req  (req),
        .i_we   (we),
        .i_addr (addr),
        .i_wdata(wdata),
        .o_ack  (ack),
        .o_rdata(rdata),
        .o_data (data),
        .o_mode (mode)
    );

    always #5 clk = ~clk;

    logic [31:0] m_data, m_pend, m_period, m_rdata;
    logic [2:0]  m_ctrl;
    logic        m_flag, m_mode, m_base, m_ack;
    longint      e, t0;

    function automatic logic cur_mode();
        longint n;
        if (!m_ctrl[0]) return m_mode;
        n = (e - t0) / longint'(m_period);
        return m_base ^ n[0];
    endfunction

    task automatic model_edge(input logic r, q, w,
                              input logic [1:0] a,
                              input logic [31:0] d);
        logic        pm;
        logic [31:0] rv;
        pm = cur_mode();
        e++;
        if (r) begin
            m_data = 32'h0; m_pend = 32'h0; m_flag = 0;
            m_ctrl = 3'd0; m_period = DEF_P; m_mode = 0;
            m_ack = 0; m_rdata = 0; m_base = 0; t0 = e;
            return;
        end
        case (a)
            2'd0: rv = m_data;
            2'd1: rv = {29'd0, m_ctrl};
            2'd2: rv = m_period;
            default: rv = {30'd0, m_flag, pm};
        endcase
        m_ack = q;
        m_rdata = (q && !w) ? rv : 32'h0;
        if (!(q && w)) return;
        case (a)
            2'd0: begin
                if (m_ctrl[2]) begin
                    m_pend = d; m_flag = 1;
                end else begin
                    m_data = d;
                end
            end
            2'd1: begin
                if (m_ctrl[2] && !d[2] && m_flag) begin
                    m_data = m_pend; m_flag = 0;
                end
                if (!d[0]) m_mode = d[1];
                else if (!m_ctrl[0]) begin
                    m_base = pm; t0 = e;
                end
                m_ctrl = d[2:0];
            end
            2'd2: begin
                m_period = (d == 0) ? 32'd1 : d;
                if (m_ctrl[0]) begin
                    m_base = pm; t0 = e;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got, exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step(input logic r, q, w,
                        input logic [1:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        rst = r; req = q; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge(r, q, w, a, d);
        #1;
        chk("data", data, m_data);
        chk("mode", {31'd0, mode}, {31'd0, cur_mode()});
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic wr_t(input logic [1:0] a, input logic [31:0] d);
        step(0, 1, 1, a, d);
    endtask

    task automatic rd_t(input logic [1:0] a);
        step(0, 1, 0, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        int          k;
        rst = 1; req = 0; we = 0; addr = 0; wdata = 0;
        e = 0; t0 = 0; m_base = 0;
        step(1, 0, 0, 2'd0, 32'h0);
        step(1, 1, 1, 2'd0, 32'h1111_1111);
        idle(1);
        rd_t(2'd2);
        idle(1);
        chk("p_def_hold", rdata, 32'h0);
        rd_t(2'd2);
        chk("p_def", rdata, DEF_P);
        wr_t(2'd0, 32'hDEADBEEF);
        chk("data_wr", data, 32'hDEADBEEF);
        wr_t(2'd1, 32'h2);
        chk("half1", {31'd0, mode}, 32'd1);
        wr_t(2'd1, 32'h0);
        wr_t(2'd2, 32'd4);
        wr_t(2'd1, 32'h1);
        idle(13);
        wr_t(2'd2, 32'd0);
        rd_t(2'd2);
        chk("p_zero", rdata, 32'd1);
        idle(5);
        wr_t(2'd1, 32'h4);
        wr_t(2'd0, 32'h12345678);
        wr_t(2'd0, 32'h9ABCDEF0);
        rd_t(2'd3);
        chk("stat_pend", rdata & 32'h2, 32'h2);
        wr_t(2'd1, 32'h0);
        chk("release", data, 32'h9ABCDEF0);
        wr_t(2'd0, 32'hCAFE0001);
        rd_t(2'd0);
        chk("b2b_rd", rdata, 32'hCAFE0001);
        rd_t(2'd3);
        wr_t(2'd3, 32'hFFFFFFFF);
        idle(2);
        wr_t(2'd2, 32'd8);
        wr_t(2'd1, 32'h1);
        idle(5);
        step(1, 0, 0, 2'd0, 32'h0);
        idle(20);
        rd_t(2'd1);
        chk("auto_off", rdata, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 99);
            d = $urandom;
            if (k == 0) begin
                step(1, 0, 0, 2'd0, 32'h0);
            end else if (k < 40) begin
                idle(1);
            end else if (k < 55) begin
                rd_t(2'(d[1:0]));
            end else if (k < 70) begin
                wr_t(2'd0, d);
            end else if (k < 85) begin
                wr_t(2'd1, {29'd0, d[10:8]});
            end else if (k < 97) begin
                wr_t(2'd2, {29'd0, d[6:4]});
            end else if (k < 98) begin
                wr_t(2'd2, d);
            end else begin
                wr_t(2'd3, d);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seven_segment_ctrl.md
Name: seven_segment_ctrl

Overview:
- Memory-mapped controller that sequences the 4-digit, 32-bit hex display path.
- Holds the displayed word and drives the half-select (upper/lower 16 bits) feeding seven_segment_32bit.
- Half-select is either CPU-chosen or auto-alternated on a programmable dwell period.
- Sits on the CPU peripheral bus next to the display decoder.

Parameters:
- DEFAULT_PERIOD, 50000000, reset dwell count in clock cycles (1 s at 50 MHz); value 0 is treated as 1.
- RESET_DATA, 32'h00000000, o_data value after reset.

Ports:
- i_clk  input  1  system clock, all logic rising-edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  1  bus request, one transfer per cycle high.
- i_we  input  1  1 = write, 0 = read; qualified by i_req.
- i_addr  input  2  register select.
- i_wdata  input  32  write data.
- o_ack  output  1  one-cycle acknowledge.
- o_rdata  output  32  read data, valid when o_ack=1, else 0.
- o_data  output  32  word to display (to i_data of display).
- o_mode  output  1  half select (to i_mode): 1 = bits 31:16, 0 = bits 15:0.

Behaviour:
- Reset (i_rst high at clock edge):
  - o_data=RESET_DATA, o_mode=0, o_ack=0, o_rdata=0.
  - CTRL=0, PERIOD=DEFAULT_PERIOD (0→1), counter=0, PENDING=0, pending_flag=0.
  - Reset overrides any bus request in the same cycle; reset mid-dwell discards count.
- Registers:
  - addr 0 DATA: read returns o_data.
    - Write with FREEZE=0: o_data updated at that edge (visible next cycle).
    - Write with FREEZE=1: value stored in PENDING, pending_flag=1, o_data unchanged; later write overwrites PENDING.
  - addr 1 CTRL (bits 2:0 stored, rest read 0): bit0 AUTO, bit1 HALF (manual select), bit2 FREEZE.
  - addr 2 PERIOD: 32-bit; write 0 stores 1; write also clears counter.
  - addr 3 STATUS, read-only (writes acked, ignored): bit0=o_mode, bit1=pending_flag, rest 0.
- Bus timing:
  - Request sampled at edge N; o_ack=1 and o_rdata valid in cycle N+1 only.
  - Back-to-back requests give back-to-back acks; no wait states, no stall.
  - Writes take effect at edge N (register new value visible in N+1 reads).
- Freeze release: CTRL write changing FREEZE 1→0 with pending_flag=1 loads o_data=PENDING, clears pending_flag, same edge.
- Mode state machine, two states:
  - MANUAL (AUTO=0): o_mode follows HALF, registered; counter held at 0.
  - ALTERNATE (AUTO=1):
    - counter increments each cycle.
    - When counter==PERIOD-1: o_mode toggles and counter returns to 0, so o_mode toggles every PERIOD cycles; PERIOD=1 toggles every cycle.
  - MANUAL→ALTERNATE (CTRL write AUTO 0→1): counter=0, o_mode keeps current value, first toggle PERIOD cycles after write edge.
  - ALTERNATE→MANUAL: o_mode=new HALF at write edge, counter=0.
  - CTRL write keeping AUTO=1 leaves counter running.
  - PERIOD write in ALTERNATE: counter=0. If it coincides with the terminal count, no toggle that cycle; new period measured from write edge.
- Counter is 32-bit; never exceeds PERIOD-1, no wrap hazard.

Test Plan:
- Reset with bus idle → o_data=0, o_mode=0, o_ack=0. Read addr 2 → o_ack next cycle, o_rdata=DEFAULT_PERIOD.
- Write DATA=32'hDEADBEEF → o_data=DEADBEEF next cycle. CTRL=3'b010 → o_mode=1. CTRL=0 → o_mode=0.
- PERIOD=4, CTRL=1 → o_mode toggles exactly every 4 cycles (edges W+4, W+8, …). PERIOD=0 → reads back 1, o_mode toggles every cycle.
- CTRL=3'b100, DATA=12345678 then 9ABCDEF0 → o_data unchanged, STATUS=2'b10. CTRL=0 → o_data=9ABCDEF0, STATUS bit1=0.
- Four back-to-back requests (write DATA, read DATA, read STATUS, write addr 3) → four consecutive acks. Read DATA returns new value. addr 3 write has no effect.
- In ALTERNATE with PERIOD=8, assert i_rst at counter=5 → next cycle all outputs at reset values, AUTO=0, no further toggles.
